// File: rtl/raycast_pkg.sv
// raycast_pkg: shared fixed-point types and helpers for the raycaster column
// generator.
//   fp88_t    - signed 8.8 fixed point value
//   FRAC_BITS - fractional bits of fp88_t
//   FP_ONE    - 1.0 in 8.8
//   state_t   - column generator FSM states
//   sat16     - clamp a 17-bit signed sum into the fp88_t range
package raycast_pkg;

  typedef logic signed [15:0] fp88_t;

  localparam int    FRAC_BITS = 8;
  localparam fp88_t FP_ONE    = 16'sh0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic fp88_t sat16(input logic signed [16:0] x);
    if (x > 17'sd32767)
      return 16'sh7FFF;
    else if (x < -17'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage

// File: rtl/fp_mul_8_8.sv
// fp_mul_8_8: one-cycle registered signed 8.8 x 8.8 multiply.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset (clears the product)
//   en  - load enable; the product register holds while low
//   a,b - signed 8.8 operands
//   p   - registered 8.8 product, bits [23:8] of the full 32-bit product
module fp_mul_8_8
  import raycast_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  fp88_t a,
  input  fp88_t b,
  output fp88_t p
);

  logic signed [31:0] full;
  logic               full_unused;

  assign full = a * b;

  // Integer bits above 8.8 range and the dropped fraction are discarded
  // (wraps rather than saturates, matching the downstream adder's input).
  assign full_unused = ^{full[31:FRAC_BITS+16], full[FRAC_BITS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      p <= '0;
    else if (en)
      p <= full[FRAC_BITS+15:FRAC_BITS];
  end

endmodule

// File: rtl/ray_column_gen.sv
// ray_column_gen: once per frame, emits one ray direction per screen column.
//   cameraX = 2*col/W - 1, rayDir = dir + plane*cameraX (8.8, saturated).
// Ports:
//   clk_in, rst_in                    - clock, async active-high reset
//   start_in                          - frame start pulse, honoured only when idle
//   posX_in..planeY_in                - pose, latched at start
//   ready_in                          - downstream accepts current ray
//   valid_out, col_out                - ray valid and its column index
//   rayDirX_out, rayDirY_out          - ray direction (8.8)
//   posX_out, posY_out                - position latched for this frame
//   busy_out                          - frame in progress
//   frame_done_out                    - pulse the cycle after column W-1 is accepted
//   state_out                         - FSM state, for observation
// Handshake: a ray transfers on a clock edge where valid_out & ready_in; while
// valid_out & ~ready_in every output is held unchanged. All three pipeline
// stages advance together on adv = ~valid_out | ready_in.
module ray_column_gen
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH = 320,
  parameter int COL_W        = $clog2(SCREEN_WIDTH),
  parameter int CAM_STEP     = (2**17 + SCREEN_WIDTH/2) / SCREEN_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [15:0]      posX_in,
  input  logic [15:0]      posY_in,
  input  logic [15:0]      dirX_in,
  input  logic [15:0]      dirY_in,
  input  logic [15:0]      planeX_in,
  input  logic [15:0]      planeY_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [COL_W-1:0] col_out,
  output logic [15:0]      rayDirX_out,
  output logic [15:0]      rayDirY_out,
  output logic [15:0]      posX_out,
  output logic [15:0]      posY_out,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic [1:0]       state_out
);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(SCREEN_WIDTH - 1);
  localparam logic signed [24:0] CAM_INC  = 25'(CAM_STEP);
  // -1.0 in 8.16
  localparam logic signed [24:0] ACC_INIT = -(25'(FP_ONE) <<< FRAC_BITS);

  state_t             state;
  fp88_t              pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;
  logic [COL_W-1:0]   col_cnt;
  logic signed [24:0] acc;
  logic               acc_unused;
  logic               adv;

  logic               s0_valid;
  logic [COL_W-1:0]   s0_col;
  fp88_t              s0_cam;
  logic               s1_valid;
  logic [COL_W-1:0]   s1_col;
  fp88_t              prod_x, prod_y;
  logic signed [16:0] sum_x, sum_y;

  assign adv        = ~valid_out | ready_in;
  assign state_out  = state;
  assign posX_out   = pos_x;
  assign posY_out   = pos_y;
  // acc carries 8.16; only the 8.8 window feeds cameraX
  assign acc_unused = ^{acc[24], acc[7:0]};

  // Frame control: pose latch, column counter, cameraX accumulator.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pos_x          <= '0;
      pos_y          <= '0;
      dir_x          <= '0;
      dir_y          <= '0;
      plane_x        <= '0;
      plane_y        <= '0;
      col_cnt        <= '0;
      acc            <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            pos_x    <= posX_in;
            pos_y    <= posY_in;
            dir_x    <= dirX_in;
            dir_y    <= dirY_in;
            plane_x  <= planeX_in;
            plane_y  <= planeY_in;
            col_cnt  <= '0;
            acc      <= ACC_INIT;
            busy_out <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (adv) begin
            col_cnt <= col_cnt + COL_W'(1);
            acc     <= acc + CAM_INC;
            if (col_cnt == LAST_COL)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_out && ready_in && col_out == LAST_COL) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fp_mul_8_8 u_mul_x (
    .clk (clk_in),
    .rst (rst_in),
    .en  (adv),
    .a   (plane_x),
    .b   (s0_cam),
    .p   (prod_x)
  );

  fp_mul_8_8 u_mul_y (
    .clk (clk_in),
    .rst (rst_in),
    .en  (adv),
    .a   (plane_y),
    .b   (s0_cam),
    .p   (prod_y)
  );

  assign sum_x = $signed({dir_x[15], dir_x}) + $signed({prod_x[15], prod_x});
  assign sum_y = $signed({dir_y[15], dir_y}) + $signed({prod_y[15], prod_y});

  // S0 issue -> S1 multiply (inside fp_mul_8_8) -> S2 add/saturate to outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s0_valid    <= 1'b0;
      s0_col      <= '0;
      s0_cam      <= '0;
      s1_valid    <= 1'b0;
      s1_col      <= '0;
      valid_out   <= 1'b0;
      col_out     <= '0;
      rayDirX_out <= '0;
      rayDirY_out <= '0;
    end else if (adv) begin
      s0_valid    <= (state == ISSUE);
      s0_col      <= col_cnt;
      s0_cam      <= acc[23:8];
      s1_valid    <= s0_valid;
      s1_col      <= s0_col;
      valid_out   <= s1_valid;
      col_out     <= s1_col;
      rayDirX_out <= sat16(sum_x);
      rayDirY_out <= sat16(sum_y);
    end
  end

endmodule

// File: tb/tb_ray_column_gen.sv
// tb_ray_column_gen: bench for ray_column_gen with W=320. A reference model
// computes every ray of a frame from the pose with plain integer arithmetic
// and queues them at frame start; a negedge monitor compares every valid ray
// against the head of that queue and pops on transfer.
module tb_ray_column_gen;

  localparam int W        = 320;
  localparam int COL_W    = 9;
  localparam int CAM_STEP = 410;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [15:0]      posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in;
  logic             ready_in;
  logic             valid_out;
  logic [COL_W-1:0] col_out;
  logic [15:0]      rayDirX_out, rayDirY_out, posX_out, posY_out;
  logic             busy_out, frame_done_out;
  logic [1:0]       state_out;

  ray_column_gen #(.SCREEN_WIDTH(W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .posX_in        (posX_in),
    .posY_in        (posY_in),
    .dirX_in        (dirX_in),
    .dirY_in        (dirY_in),
    .planeX_in      (planeX_in),
    .planeY_in      (planeY_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .col_out        (col_out),
    .rayDirX_out    (rayDirX_out),
    .rayDirY_out    (rayDirY_out),
    .posX_out       (posX_out),
    .posY_out       (posY_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .state_out      (state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [40:0] exp_q[$];       // {col, rayDirX, rayDirY}
  logic [15:0] exp_px, exp_py;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  logic [15:0] cap_rx[W];
  logic [15:0] cap_ry[W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cameraX = floor((-1.0 + col*step) in 8.16 to 8.8),
  // product keeps 8.8 bits [23:8] (wrapping), sum saturates to 16 bits.
  function automatic logic [15:0] ref_ray(input int col, input logic signed [15:0] d,
                                          input logic signed [15:0] pl);
    longint      cam, prod, t, s;
    logic [15:0] tw;
    cam  = (longint'(col) * CAM_STEP - 65536) >>> 8;
    prod = longint'(pl) * cam;
    t    = prod >>> 8;
    tw   = t[15:0];
    s    = longint'(d) + longint'($signed(tw));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (frame_done_out) done_cnt++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(valid_out), 32'd0);
        end else begin
          check("col",      32'(col_out),     32'(exp_q[0][40:32]));
          check("rayDirX",  32'(rayDirX_out), 32'(exp_q[0][31:16]));
          check("rayDirY",  32'(rayDirY_out), 32'(exp_q[0][15:0]));
          check("posX_out", 32'(posX_out),    32'(exp_px));
          check("posY_out", 32'(posY_out),    32'(exp_py));
          if (ready_in) begin
            cap_rx[int'(col_out) % W] = rayDirX_out;
            cap_ry[int'(col_out) % W] = rayDirY_out;
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is at posedge+1; start is sampled at the next edge (cycle N).
  task automatic start_frame_now(input logic [15:0] px, py, dx, dy, plx, ply);
    posX_in = px; posY_in = py; dirX_in = dx; dirY_in = dy;
    planeX_in = plx; planeY_in = ply; start_in = 1'b1;
    exp_px = px; exp_py = py; xfer_cnt = 0;
    for (int c = 0; c < W; c++)
      exp_q.push_back({COL_W'(c), ref_ray(c, dx, plx), ref_ray(c, dy, ply)});
    @(posedge clk_in); #1;
    start_in  = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic check_first_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (valid_out) break;
    end
    check("first_valid_latency", 32'(cyc - start_cyc), 32'd3);
  endtask

  // Returns at posedge+1 of the frame_done cycle; optionally randomizes ready.
  task automatic wait_done(input bit rnd_ready);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in); #1;
      if (frame_done_out) begin ok = 1'b1; break; end
      ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    ready_in = 1'b1;
    check("frame_done_seen", 32'(ok), 32'd1);
    check("busy_low_at_done", 32'(busy_out), 32'd0);
    check("xfer_count", 32'(xfer_cnt), W);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_col(input int c);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_in); #1;
      if (valid_out && int'(col_out) == c) begin ok = 1'b1; break; end
    end
    check("reach_col", 32'(ok), 32'd1);
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1;
    posX_in = '0; posY_in = '0; dirX_in = '0; dirY_in = '0;
    planeX_in = '0; planeY_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(frame_done_out), 32'd0);
    check("rst_col", 32'(col_out), 32'd0);
    check("rst_rayX", 32'(rayDirX_out), 32'd0);
    check("rst_rayY", 32'(rayDirY_out), 32'd0);
    check("rst_posX", 32'(posX_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;

    // Directed frame: latency, key rays, frame_done timing
    start_frame_now(16'h1234, 16'h0567, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    check("busy_after_start", 32'(busy_out), 32'd1);
    check_first_valid();
    wait_done(1'b0);
    check("done_cycle", 32'(cyc - start_cyc), 32'd323);
    check("col0_rayX", 32'(cap_rx[0]), 32'h0100);
    check("col0_rayY", 32'(cap_ry[0]), 32'hFF57);
    check("col160_rayY", 32'(cap_ry[160]), 32'h0000);
    check("col319_rayY", 32'(cap_ry[319]), 32'h00A7);
    @(negedge clk_in);
    check("posX_hold", 32'(posX_out), 32'h1234);

    // Saturation, positive and negative
    @(posedge clk_in); #1;
    start_frame_now(16'h0, 16'h0, 16'h0100, 16'h7F00, 16'h0000, 16'h7F00);
    wait_done(1'b0);
    check("sat_pos_col319", 32'(cap_ry[319]), 32'h7FFF);
    @(posedge clk_in); #1;
    start_frame_now(16'h0, 16'h0, 16'h0100, 16'h8100, 16'h0000, 16'h7F00);
    wait_done(1'b0);
    check("sat_neg_col0", 32'(cap_ry[0]), 32'h8000);

    // Back-pressure on column 10
    @(posedge clk_in); #1;
    start_frame_now(rnd16(), rnd16(), 16'h00B5, 16'hFF4B, 16'h0060, 16'h0060);
    wait_col(10);
    ready_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      check("bp_col_held", 32'(col_out), 32'd10);
      check("bp_valid_held", 32'(valid_out), 32'd1);
    end
    @(posedge clk_in); #1;
    ready_in = 1'b1;
    wait_done(1'b0);

    // Mid-frame pose change and ignored start
    @(posedge clk_in); #1;
    start_frame_now(16'h0A00, 16'h0B00, 16'h0000, 16'h0100, 16'hFF57, 16'h0000);
    d0 = done_cnt;
    wait_col(50);
    posX_in = rnd16(); posY_in = rnd16(); dirX_in = rnd16(); dirY_in = rnd16();
    planeX_in = rnd16(); planeY_in = rnd16(); start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_done(1'b0);
    repeat (6) @(negedge clk_in);
    check("disturb_one_done", 32'(done_cnt - d0), 32'd1);
    check("disturb_no_restart_busy", 32'(busy_out), 32'd0);
    check("disturb_no_restart_valid", 32'(valid_out), 32'd0);

    // Random poses with random back-pressure
    for (int f = 0; f < 3; f++) begin
      @(posedge clk_in); #1;
      start_frame_now(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      wait_done(1'b1);
    end

    // Back-to-back: start in the frame_done cycle
    @(posedge clk_in); #1;
    start_frame_now(rnd16(), rnd16(), 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
    wait_done(1'b0);
    start_frame_now(rnd16(), rnd16(), rnd16(), rnd16(), 16'h0040, 16'hFFC0);
    check("b2b_busy_back", 32'(busy_out), 32'd1);
    check("b2b_done_single", 32'(frame_done_out), 32'd0);
    check_first_valid();
    wait_done(1'b0);

    // Async reset mid-frame
    @(posedge clk_in); #1;
    start_frame_now(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    wait_col(100);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_busy", 32'(busy_out), 32'd0);
    check("arst_col", 32'(col_out), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    check("arst_idle_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in); #1;
    start_frame_now(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    check_first_valid();
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
